// File: rtl/relu_maxpool2x2_if.sv
// relu_maxpool2x2_if
// Bundles the job handshake and data buses of the ReLU + 2x2 max-pool stage.
//   master : job producer (drives start/rows/cols/relu_en/fmap_data, observes results)
//   slave  : the pooling stage (consumes job inputs, drives pooled_matrix/out dims/busy/done/err)
// Words are total_bits wide two's complement; the input vector is packed with
// the runtime column count, the output vector with the runtime pooled column count.
interface relu_maxpool2x2_if #(
    parameter int total_bits = 16,
    parameter int max_rows   = 6,
    parameter int max_cols   = 6
);
    logic                                             start;
    logic [3:0]                                       rows;
    logic [3:0]                                       cols;
    logic                                             relu_en;
    logic [max_rows*max_cols*total_bits-1:0]          fmap_data;
    logic [(max_rows/2)*(max_cols/2)*total_bits-1:0]  pooled_matrix;
    logic [3:0]                                       out_rows;
    logic [3:0]                                       out_cols;
    logic                                             busy;
    logic                                             done;
    logic                                             err;

    modport master (
        output start, rows, cols, relu_en, fmap_data,
        input  pooled_matrix, out_rows, out_cols, busy, done, err
    );

    modport slave (
        input  start, rows, cols, relu_en, fmap_data,
        output pooled_matrix, out_rows, out_cols, busy, done, err
    );
endinterface

// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2
// Optional ReLU followed by a 2x2 stride-2 signed max-pool over a flattened
// feature map. The whole input map is snapshotted when a job is accepted, so
// the upstream producer is free to start its next job right away.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : relu_maxpool2x2_if.slave -- start/rows/cols/relu_en/fmap_data in,
//          pooled_matrix/out_rows/out_cols/busy/done/err out
// Each output window takes three cycles (LOAD, COMPARE, STORE) after a single
// CAPTURE cycle that validates the dimensions; done and err are sticky until
// the next accepted start.
module relu_maxpool2x2 #(
    parameter int total_bits = 16,
    parameter int frac_bits  = 8,
    parameter int max_rows   = 6,
    parameter int max_cols   = 6
) (
    input  logic              clk,
    input  logic              rst,
    relu_maxpool2x2_if.slave  bus
);
    localparam int InWords  = max_rows * max_cols;
    localparam int OutWords = (max_rows / 2) * (max_cols / 2);
    localparam int InIdxW   = $clog2(InWords);
    localparam int OutIdxW  = $clog2(OutWords);
    localparam logic [3:0] MaxRows4 = 4'(max_rows);
    localparam logic [3:0] MaxCols4 = 4'(max_cols);

    typedef enum logic [2:0] {IDLE, CAPTURE, LOAD, COMPARE, STORE} state_t;

    state_t                                  state_q, state_d;
    logic [InWords-1:0][total_bits-1:0]      snap_q, snap_d;
    logic [OutWords-1:0][total_bits-1:0]     pooled_q, pooled_d;
    logic [3:0]                              rows_q, rows_d, cols_q, cols_d;
    logic                                    relu_q, relu_d;
    logic [3:0]                              outRows_q, outRows_d, outCols_q, outCols_d;
    logic [3:0]                              pr_q, pr_d, pc_q, pc_d;
    logic [total_bits-1:0]                   pixA_q, pixA_d, pixB_q, pixB_d;
    logic [total_bits-1:0]                   pixC_q, pixC_d, pixD_q, pixD_d;
    logic [total_bits-1:0]                   max_q, max_d;
    logic                                    busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [7:0]                              base0, base1, colOff, idxA, idxC, slot;
    logic [total_bits-1:0]                   m0, m1, m;
    logic                                    dimsBad;

    // Window addressing: the snapshot is packed with the latched cols, so the
    // top-left pixel of window (pr,pc) sits at 2pr*cols + 2pc and the row
    // below it one cols-stride further on.
    always_comb begin
        base0  = 8'({pr_q, 1'b0}) * {4'd0, cols_q};
        base1  = base0 + {4'd0, cols_q};
        colOff = {3'd0, pc_q, 1'b0};
        idxA   = base0 + colOff;
        idxC   = base1 + colOff;
        slot   = 8'(pr_q) * {4'd0, outCols_q} + {4'd0, pc_q};
    end

    // Two-level signed max tree, then the optional clamp of negatives to zero.
    always_comb begin
        m0 = ($signed(pixA_q) > $signed(pixB_q)) ? pixA_q : pixB_q;
        m1 = ($signed(pixC_q) > $signed(pixD_q)) ? pixC_q : pixD_q;
        m  = ($signed(m0) > $signed(m1)) ? m0 : m1;
        if (relu_q && m[total_bits-1]) begin
            m = '0;
        end
    end

    assign dimsBad = (rows_q < 4'd2) || (cols_q < 4'd2) ||
                     (rows_q > MaxRows4) || (cols_q > MaxCols4);

    // Next-state and datapath updates for the job sequencer.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        pooled_d  = pooled_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        relu_d    = relu_q;
        outRows_d = outRows_q;
        outCols_d = outCols_q;
        pr_d      = pr_q;
        pc_d      = pc_q;
        pixA_d    = pixA_q;
        pixB_d    = pixB_q;
        pixC_d    = pixC_q;
        pixD_d    = pixD_q;
        max_d     = max_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d  = bus.fmap_data;
                    rows_d  = bus.rows;
                    cols_d  = bus.cols;
                    relu_d  = bus.relu_en;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (dimsBad) begin
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    outRows_d = 4'd0;
                    outCols_d = 4'd0;
                    state_d   = IDLE;
                end else begin
                    pooled_d  = '0;
                    outRows_d = rows_q >> 1;
                    outCols_d = cols_q >> 1;
                    pr_d      = 4'd0;
                    pc_d      = 4'd0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                pixA_d  = snap_q[idxA[InIdxW-1:0]];
                pixB_d  = snap_q[InIdxW'(idxA + 8'd1)];
                pixC_d  = snap_q[idxC[InIdxW-1:0]];
                pixD_d  = snap_q[InIdxW'(idxC + 8'd1)];
                state_d = COMPARE;
            end
            COMPARE: begin
                max_d   = m;
                state_d = STORE;
            end
            STORE: begin
                pooled_d[slot[OutIdxW-1:0]] = max_q;
                if (pc_q + 4'd1 < outCols_q) begin
                    pc_d    = pc_q + 4'd1;
                    state_d = LOAD;
                end else if (pr_q + 4'd1 < outRows_q) begin
                    pc_d    = 4'd0;
                    pr_d    = pr_q + 4'd1;
                    state_d = LOAD;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset mid-job discards everything, including partial results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            pooled_q  <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            relu_q    <= 1'b0;
            outRows_q <= '0;
            outCols_q <= '0;
            pr_q      <= '0;
            pc_q      <= '0;
            pixA_q    <= '0;
            pixB_q    <= '0;
            pixC_q    <= '0;
            pixD_q    <= '0;
            max_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            pooled_q  <= pooled_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            relu_q    <= relu_d;
            outRows_q <= outRows_d;
            outCols_q <= outCols_d;
            pr_q      <= pr_d;
            pc_q      <= pc_d;
            pixA_q    <= pixA_d;
            pixB_q    <= pixB_d;
            pixC_q    <= pixC_d;
            pixD_q    <= pixD_d;
            max_q     <= max_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.pooled_matrix = pooled_q;
    assign bus.out_rows      = outRows_q;
    assign bus.out_cols      = outCols_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb_relu_maxpool2x2
// Drives pooling jobs through the interface, pushes the expected result of
// each job onto a scoreboard queue when it is started, and pops/compares it
// when done rises.
module tb_relu_maxpool2x2;
    localparam int TB   = 16;
    localparam int MR   = 6;
    localparam int MC   = 6;
    localparam int InW  = MR * MC * TB;
    localparam int OutW = (MR / 2) * (MC / 2) * TB;

    typedef struct packed {
        logic [OutW-1:0] pooled;
        logic [3:0]      oRows;
        logic [3:0]      oCols;
        logic            err;
        logic [31:0]     latency;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    relu_maxpool2x2_if #(.total_bits(TB), .max_rows(MR), .max_cols(MC)) bus ();

    relu_maxpool2x2 #(.total_bits(TB), .frac_bits(8), .max_rows(MR), .max_cols(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt++;

    int              errCount   = 0;
    int              checkCount = 0;
    int              acceptCycle = 0;
    expect_t         expQ[$];
    logic [OutW-1:0] modelPooled = '0;
    logic [InW-1:0]  fmap;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [OutW-1:0] obs, input logic [OutW-1:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Golden model: brute-force signed max over each 2x2 window.
    function automatic logic [OutW-1:0] poolModel(input logic [InW-1:0] f, input int r, input int c, input bit relu);
        logic [OutW-1:0]       o;
        logic signed [TB-1:0]  best;
        logic signed [TB-1:0]  v;
        int                    oc;
        o  = '0;
        oc = c / 2;
        for (int pr = 0; pr < r / 2; pr++) begin
            for (int pc = 0; pc < oc; pc++) begin
                best = f[((2 * pr) * c + 2 * pc) * TB +: TB];
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        v = f[((2 * pr + dr) * c + 2 * pc + dc) * TB +: TB];
                        if (v > best) best = v;
                    end
                end
                if (relu && best < 0) best = '0;
                o[(pr * oc + pc) * TB +: TB] = best;
            end
        end
        return o;
    endfunction

    // Pushes the expectation, then issues a one-cycle start with the current fmap.
    task automatic applyStimulus(input int r, input int c, input bit relu);
        expect_t e;
        bit      legal;
        legal = (r >= 2) && (c >= 2) && (r <= MR) && (c <= MC);
        if (legal) begin
            e.pooled  = poolModel(fmap, r, c, relu);
            e.oRows   = 4'(r / 2);
            e.oCols   = 4'(c / 2);
            e.err     = 1'b0;
            e.latency = 32'(1 + 3 * (r / 2) * (c / 2));
            modelPooled = e.pooled;
        end else begin
            e.pooled  = modelPooled;
            e.oRows   = 4'd0;
            e.oCols   = 4'd0;
            e.err     = 1'b1;
            e.latency = 32'd1;
        end
        expQ.push_back(e);
        @(negedge clk);
        bus.rows      = 4'(r);
        bus.cols      = 4'(c);
        bus.relu_en   = relu;
        bus.fmap_data = fmap;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        acceptCycle = cycleCnt;
        checkOutput("accept_done_clear", bus.done, 1'b0);
        checkOutput("accept_busy_set", bus.busy, 1'b1);
    endtask

    // Bounded wait for done, then compare against the oldest expectation.
    task automatic waitAndCheck(input string tag);
        expect_t e;
        int      budget;
        budget = 200;
        while (!bus.done && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (!bus.done) begin
            checkOutput({tag, "_done_timeout"}, bus.done, 1'b1);
            return;
        end
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 0, 1);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, "_latency"}, OutW'(cycleCnt - acceptCycle), OutW'(e.latency));
        checkOutput({tag, "_pooled"}, bus.pooled_matrix, e.pooled);
        checkOutput({tag, "_out_rows"}, bus.out_rows, e.oRows);
        checkOutput({tag, "_out_cols"}, bus.out_cols, e.oCols);
        checkOutput({tag, "_err"}, bus.err, e.err);
        checkOutput({tag, "_busy_low"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.rows      = 4'd0;
        bus.cols      = 4'd0;
        bus.relu_en   = 1'b0;
        bus.fmap_data = '0;
        fmap          = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset_pooled", bus.pooled_matrix, '0);
        checkOutput("reset_out_rows", bus.out_rows, 4'd0);
        checkOutput("reset_out_cols", bus.out_cols, 4'd0);
        checkOutput("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_done", bus.done, 1'b0);
        checkOutput("reset_err", bus.err, 1'b0);

        // 4x4 ramp without ReLU
        fmap = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                fmap[(r * 4 + c) * TB +: TB] = 16'(16'h0100 * (r * 4 + c));
        applyStimulus(4, 4, 1'b0);
        waitAndCheck("ramp");
        checkOutput("ramp_const", bus.pooled_matrix,
                    OutW'({16'h0F00, 16'h0D00, 16'h0700, 16'h0500}));

        // 4x4 all negative: signed max, then ReLU clamps to zero
        fmap = '0;
        for (int i = 0; i < 16; i++) fmap[i * TB +: TB] = 16'hFF00;
        fmap[(1 * 4 + 1) * TB +: TB] = 16'hFE00;
        applyStimulus(4, 4, 1'b0);
        waitAndCheck("neg_norelu");
        checkOutput("neg_norelu_const", bus.pooled_matrix, OutW'({4{16'hFF00}}));
        applyStimulus(4, 4, 1'b1);
        waitAndCheck("neg_relu");

        // 5x3 odd dimensions: trailing row and column dropped
        fmap = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 3; c++)
                fmap[(r * 3 + c) * TB +: TB] = 16'((r * 3 + c) * 16'h0111) - 16'h0700;
        fmap[(4 * 3 + 0) * TB +: TB] = 16'h7F00;
        fmap[(0 * 3 + 2) * TB +: TB] = 16'h7E00;
        applyStimulus(5, 3, 1'b0);
        waitAndCheck("odd5x3");

        // Illegal dimensions leave the previous pooled result in place
        applyStimulus(1, 4, 1'b0);
        waitAndCheck("bad_rows");
        applyStimulus(4, 7, 1'b0);
        waitAndCheck("bad_cols");

        // Start during a job is ignored and the snapshot protects the result
        fmap = '0;
        for (int i = 0; i < 16; i++) fmap[i * TB +: TB] = 16'($urandom);
        applyStimulus(4, 4, 1'b0);
        repeat (3) @(negedge clk);
        bus.start     = 1'b1;
        bus.rows      = 4'd2;
        bus.cols      = 4'd2;
        bus.fmap_data = ~fmap;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("midjob_busy", bus.busy, 1'b1);
        waitAndCheck("midjob");

        // A few random legal jobs, each a restart while done is high
        for (int j = 0; j < 4; j++) begin
            int r;
            int c;
            r = int'($urandom_range(2, MR));
            c = int'($urandom_range(2, MC));
            fmap = '0;
            for (int i = 0; i < r * c; i++) fmap[i * TB +: TB] = 16'($urandom);
            applyStimulus(r, c, 1'($urandom_range(0, 1)));
            waitAndCheck("random");
        end

        // Asynchronous reset during the 5th cycle of a 6x6 job
        fmap = '0;
        for (int i = 0; i < 36; i++) fmap[i * TB +: TB] = 16'($urandom);
        applyStimulus(6, 6, 1'b1);
        expQ = {};
        modelPooled = '0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_pooled", bus.pooled_matrix, '0);
        checkOutput("abort_out_rows", bus.out_rows, 4'd0);
        checkOutput("abort_out_cols", bus.out_cols, 4'd0);
        checkOutput("abort_busy", bus.busy, 1'b0);
        checkOutput("abort_done", bus.done, 1'b0);
        checkOutput("abort_err", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(6, 6, 1'b0);
        waitAndCheck("after_reset");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/relu_maxpool2x2.md
Name: relu_maxpool2x2

Overview:
- Downstream stage of the 3x3 convolution unit. It consumes that unit's flattened filtered matrix and its done flag.
- It applies an optional ReLU and a 2x2 stride-2 signed max-pool, and writes a flattened pooled matrix with a start/busy/done handshake.
- The input is snapshotted on start, so upstream may begin a new job immediately.

Parameters:
- total_bits, 16, fixed-point word width (two's complement).
- frac_bits, 8, fractional bits. Carried for consistency only; pooling and ReLU are format-agnostic.
- max_rows, 6, maximum input feature-map rows (convolution max_rows-2).
- max_cols, 6, maximum input feature-map columns (convolution max_cols-2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  one-cycle job request; typically the rising edge of the convolution done
- rows  input  4  input feature-map rows, sampled on accepted start
- cols  input  4  input feature-map cols, sampled on accepted start
- relu_en  input  1  1 = clamp negative results to 0; sampled on accepted start
- fmap_data  input  max_rows*max_cols*total_bits  flattened input; element (r,c) at bit (r*cols+c)*total_bits, packed with the runtime cols
- pooled_matrix  output  (max_rows/2)*(max_cols/2)*total_bits  flattened output; element (r,c) at bit (r*out_cols+c)*total_bits
- out_rows  output  4  floor(rows/2) of the current job
- out_cols  output  4  floor(cols/2) of the current job
- busy  output  1  high from accept through the last STORE
- done  output  1  sticky completion flag
- err  output  1  sticky; set when the job had illegal dimensions

Behaviour:
- Reset (rst=0, asynchronous):
  - pooled_matrix, out_rows, out_cols, busy, done and err all go to 0.
  - The FSM goes to IDLE, and row/col counters go to 0.
  - Reset mid-job aborts immediately; no partial result is retained.
- FSM states: IDLE, CAPTURE, LOAD, COMPARE, STORE.
- IDLE:
  - start=1 is accepted.
  - Acceptance latches rows, cols and relu_en, and the full fmap_data into an internal snapshot register.
  - It clears done and err, and sets busy. Next state is CAPTURE.
- Start while busy is ignored and does not queue.
- Start while done=1 is a legal restart.
- CAPTURE:
  - Validate dims. Illegal means rows<2, cols<2, rows>max_rows or cols>max_cols.
  - If illegal: err<=1, done<=1, busy<=0, pooled_matrix unchanged, out_rows/out_cols<=0, go to IDLE.
  - Otherwise: pooled_matrix<=0, out_rows<=rows>>1, out_cols<=cols>>1, counters pr=pc=0, go to LOAD.
- LOAD: register the four pixels (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc) and (2pr+1,2pc+1) from the snapshot, using the latched cols as row stride. Go to COMPARE.
- COMPARE:
  - Compute the signed maximum with a two-level tree: m0=max(a,b), m1=max(c,d), m=max(m0,m1). Comparisons are signed across the full total_bits.
  - If relu_en and m<0, m=0.
  - Register the result. Go to STORE.
- STORE:
  - Write m to output slot (pr*out_cols+pc).
  - If pc<out_cols-1: pc++, go to LOAD.
  - Else if pr<out_rows-1: pc=0, pr++, go to LOAD.
  - Else: busy<=0, done<=1, go to IDLE.
- Odd rows/cols: the trailing row/column is dropped (floor). No padding.
- Latency: accept edge, then 1 CAPTURE cycle, then 3 cycles per output window. done rises on the edge ending the last STORE.
  - Total is 1+3*out_rows*out_cols cycles after the accept edge; 6x6 input gives 28 cycles.
- Output stability:
  - pooled_matrix entries beyond out_rows*out_cols stay 0.
  - Each entry is valid once written. The whole vector is valid while done=1 and holds until the next accepted start.
- No arithmetic widening or saturation; output values are a subset of the input values (or 0).

Test Plan:
- 4x4 ramp, values 0x0100*(r*4+c), relu_en=0 -> out 2x2 = {0x0500,0x0700,0x0D00,0x0F00}; done exactly 13 cycles after accept; busy low afterwards.
- 4x4 all negative, every value 0xFF00 (-1.0) except (1,1)=0xFE00 (-2.0):
  - relu_en=0 -> all four outputs 0xFF00 (signed max, not unsigned).
  - relu_en=1 -> all outputs 0x0000.
- 5x3 input (odd dims), distinct values -> out_rows=2, out_cols=1, row 4 and col 2 ignored; slots 2..8 remain 0.
- rows=1 or cols=7 (7 > max_cols=6) on start -> err=1, done=1 one cycle after CAPTURE, out_rows=out_cols=0, pooled_matrix unchanged from the previous job.
- Start pulsed again mid-job, then fmap_data changed after accept -> the second start is ignored and results match the snapshot. A start while done=1 restarts: done clears on the accept edge.
- rst driven low during the 5th cycle of a 6x6 job -> all outputs 0 asynchronously; after release and a new start, the result matches the golden model.
